// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: two-master request/grant arbiter and sequencer in front of
// DataMemoryManager. Serialises single commands onto the memory port, waits out
// the read latency and returns read data with a one-cycle valid pulse.
// Build option: define DMA_ARB_ROUND_ROBIN_EN for round-robin tie-breaking;
// without it, port 0 has fixed priority on a tie.
module data_mem_arbiter #(
  parameter int unsigned RD_LAT = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  input  logic [31:0] m0_bmode_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  input  logic [31:0] m1_bmode_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  output logic        mem_wren_o,
  output logic [31:0] mem_bmode_o,
  input  logic [31:0] mem_data_i,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic [2:0] LAT_C = 3'(RD_LAT);

  state_e      state_q, state_d;
  logic        win_q, win_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] bmode_q, bmode_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;
  logic        gnt0_q, gnt0_d;
  logic        gnt1_q, gnt1_d;
  logic        rv0_q, rv0_d;
  logic        rv1_q, rv1_d;
  logic        wren_q, wren_d;
  logic        busy_q, busy_d;
  logic        pick_s;

`ifdef DMA_ARB_ROUND_ROBIN_EN
  logic        last_q, last_d;

  // Last-grant tracker: remembers which port was issued most recently
  always_comb begin
    last_d = last_q;
    if (state_q == ISSUE) begin
      last_d = win_q;
    end else begin
      last_d = last_q;
    end
  end

  // Last-grant register; port 1 after reset so port 0 wins the first tie
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

  // Winner selection: on a tie the port not granted last wins
  always_comb begin
    pick_s = 1'b0;
    if (m0_req_i && m1_req_i) begin
      pick_s = ~last_q;
    end else begin
      pick_s = ~m0_req_i;
    end
  end
`else
  // Winner selection: port 0 always wins when it requests
  always_comb begin
    pick_s = 1'b0;
    if (m0_req_i) begin
      pick_s = 1'b0;
    end else begin
      pick_s = 1'b1;
    end
  end
`endif

  // Sequencer next-state, command capture and registered output decode
  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    bmode_d  = bmode_q;
    cnt_d    = cnt_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    case (state_q)
      IDLE: begin
        if (m0_req_i || m1_req_i) begin
          win_d   = pick_s;
          we_d    = pick_s ? m1_we_i    : m0_we_i;
          addr_d  = pick_s ? m1_addr_i  : m0_addr_i;
          wdata_d = pick_s ? m1_wdata_i : m0_wdata_i;
          bmode_d = pick_s ? m1_bmode_i : m0_bmode_i;
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        cnt_d = 3'd1;
        if (we_q) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == LAT_C) begin
          if (win_q) begin
            rdata1_d = mem_data_i;
          end else begin
            rdata0_d = mem_data_i;
          end
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    gnt0_d = (state_d == ISSUE) && !win_d;
    gnt1_d = (state_d == ISSUE) && win_d;
    rv0_d  = (state_d == RESP) && !win_d;
    rv1_d  = (state_d == RESP) && win_d;
    wren_d = (state_d == ISSUE) && we_d;
    busy_d = (state_d != IDLE);
  end

  // State, command and output registers; reset forces the idle outputs at once
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      win_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 32'h0000_0000;
      wdata_q  <= 32'h0000_0000;
      bmode_q  <= 32'h0000_0000;
      cnt_q    <= 3'd0;
      rdata0_q <= 32'h0000_0000;
      rdata1_q <= 32'h0000_0000;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      rv0_q    <= 1'b0;
      rv1_q    <= 1'b0;
      wren_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      bmode_q  <= bmode_d;
      cnt_q    <= cnt_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      rv0_q    <= rv0_d;
      rv1_q    <= rv1_d;
      wren_q   <= wren_d;
      busy_q   <= busy_d;
    end
  end

  assign m0_gnt_o    = gnt0_q;
  assign m1_gnt_o    = gnt1_q;
  assign m0_rvalid_o = rv0_q;
  assign m1_rvalid_o = rv1_q;
  assign m0_rdata_o  = rdata0_q;
  assign m1_rdata_o  = rdata1_q;
  assign mem_addr_o  = addr_q;
  assign mem_data_o  = wdata_q;
  assign mem_bmode_o = bmode_q;
  assign mem_wren_o  = wren_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Testbench for data_mem_arbiter: directed scenarios plus randomized traffic,
// checked cycle by cycle against a transaction-timeline reference model.
module tb_data_mem_arbiter;

  localparam int LAT = 3;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] bmode;
  } cmd_t;

  logic        CLK = 1'b0;
  logic        RST;
  logic [1:0]  req;
  logic [1:0]  we;
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] bmode [2];
  logic        m0_gnt, m1_gnt, m0_rv, m1_rv, mem_wren, busy;
  logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdat, mem_bmode, mem_rdata;

  data_mem_arbiter #(.RD_LAT(LAT)) dut (
    .CLK(CLK), .RST(RST),
    .m0_req_i(req[0]), .m0_we_i(we[0]), .m0_addr_i(addr[0]), .m0_wdata_i(wdata[0]),
    .m0_bmode_i(bmode[0]), .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rv), .m0_rdata_o(m0_rdata),
    .m1_req_i(req[1]), .m1_we_i(we[1]), .m1_addr_i(addr[1]), .m1_wdata_i(wdata[1]),
    .m1_bmode_i(bmode[1]), .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rv), .m1_rdata_o(m1_rdata),
    .mem_addr_o(mem_addr), .mem_data_o(mem_wdat), .mem_wren_o(mem_wren),
    .mem_bmode_o(mem_bmode), .mem_data_i(mem_rdata), .busy_o(busy)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(int i);
    return 32'hA500_0000 + 32'(i) * 32'h0101_0101;
  endfunction

  // Synchronous RAM with LAT-cycle read pipeline
  logic [31:0] ram  [8];
  logic [31:0] pipe [LAT];
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 8; i++) ram[i] <= init_word(i);
      for (int i = 0; i < LAT; i++) pipe[i] <= 32'h0;
    end else begin
      if (mem_wren) ram[mem_addr[4:2]] <= mem_wdat;
      pipe[0] <= ram[mem_addr[4:2]];
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign mem_rdata = pipe[LAT-1];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  // Reference model: timeline of the single outstanding command
  int          gnt_cyc, rv_cyc, free_cyc;
  logic        win_m, we_m, last_m;
  logic [31:0] rd_val;
  cmd_t        cur_m;
  logic [31:0] exp_rd [2];
  logic [31:0] mdl_mem [8];
  logic [1:0]  obs_gnt;

  task automatic model_reset();
    gnt_cyc = -10; rv_cyc = -10; free_cyc = 0;
    win_m = 1'b0; we_m = 1'b0; last_m = 1'b1; rd_val = 32'h0;
    cur_m = '0; exp_rd[0] = 32'h0; exp_rd[1] = 32'h0; obs_gnt = 2'b00;
    for (int i = 0; i < 8; i++) mdl_mem[i] = init_word(i);
  endtask

  task automatic model_check();
    int   c;
    logic w;
    cmd_t k;
    c = cyc;
    if (c == rv_cyc) exp_rd[win_m] = rd_val;
    check_eq("m0_gnt",    32'(m0_gnt),   32'(c == gnt_cyc && !win_m));
    check_eq("m1_gnt",    32'(m1_gnt),   32'(c == gnt_cyc && win_m));
    check_eq("m0_rvalid", 32'(m0_rv),    32'(c == rv_cyc && !win_m));
    check_eq("m1_rvalid", 32'(m1_rv),    32'(c == rv_cyc && win_m));
    check_eq("mem_wren",  32'(mem_wren), 32'(c == gnt_cyc && we_m));
    check_eq("busy",      32'(busy),     32'(c >= gnt_cyc && c < free_cyc));
    check_eq("m0_rdata",  m0_rdata,  exp_rd[0]);
    check_eq("m1_rdata",  m1_rdata,  exp_rd[1]);
    check_eq("mem_addr",  mem_addr,  cur_m.addr);
    check_eq("mem_data",  mem_wdat,  cur_m.wdata);
    check_eq("mem_bmode", mem_bmode, cur_m.bmode);
    if (c >= free_cyc && (req[0] || req[1])) begin
`ifdef DMA_ARB_ROUND_ROBIN_EN
      w = (req[0] && req[1]) ? ~last_m : ~req[0];
`else
      w = ~req[0];
`endif
      last_m = w;
      k = '{we[w], addr[w], wdata[w], bmode[w]};
      cur_m = k; win_m = w; we_m = k.we; gnt_cyc = c + 1;
      if (k.we) begin
        mdl_mem[k.addr[4:2]] = k.wdata;
        rv_cyc = -10; free_cyc = c + 2;
      end else begin
        rd_val = mdl_mem[k.addr[4:2]];
        rv_cyc = c + 2 + LAT; free_cyc = c + 3 + LAT;
      end
    end
    obs_gnt = {m1_gnt, m0_gnt};
  endtask

  // Master behaviour: each port drives the head of its command queue
  cmd_t q0[$], q1[$];
  bit   rand_en = 1'b0;

  function automatic cmd_t rand_cmd();
    cmd_t k;
    k.we    = 1'($urandom_range(0, 1));
    k.addr  = 32'($urandom_range(0, 7)) << 2;
    k.wdata = $urandom;
    k.bmode = $urandom;
    return k;
  endfunction

  task automatic present(int n);
    cmd_t k;
    bit   has;
    has = (n == 0) ? (q0.size() > 0) : (q1.size() > 0);
    if (has) k = (n == 0) ? q0[0] : q1[0];
    else k = rand_cmd();
    req[n] = has; we[n] = k.we; addr[n] = k.addr; wdata[n] = k.wdata; bmode[n] = k.bmode;
  endtask

  task automatic push(int n, logic w, logic [31:0] a, logic [31:0] d, logic [31:0] b);
    cmd_t k;
    k = '{w, a, d, b};
    if (n == 0) q0.push_back(k); else q1.push_back(k);
    present(n);
  endtask

  task automatic masters_update();
    for (int n = 0; n < 2; n++) begin
      if (req[n] && obs_gnt[n]) begin
        if (n == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      end
      if (rand_en && ((n == 0) ? q0.size() : q1.size()) < 2 && $urandom_range(0, 3) == 0) begin
        if (n == 0) q0.push_back(rand_cmd()); else q1.push_back(rand_cmd());
      end
      present(n);
    end
  endtask

  task automatic step();
    @(negedge CLK);
    model_check();
    @(posedge CLK);
    #1;
    masters_update();
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_m0_gnt"},   32'(m0_gnt),   32'h0);
    check_eq({tag, "_m1_gnt"},   32'(m1_gnt),   32'h0);
    check_eq({tag, "_m0_rv"},    32'(m0_rv),    32'h0);
    check_eq({tag, "_m1_rv"},    32'(m1_rv),    32'h0);
    check_eq({tag, "_wren"},     32'(mem_wren), 32'h0);
    check_eq({tag, "_busy"},     32'(busy),     32'h0);
    check_eq({tag, "_m0_rdata"}, m0_rdata,  32'h0);
    check_eq({tag, "_m1_rdata"}, m1_rdata,  32'h0);
    check_eq({tag, "_addr"},     mem_addr,  32'h0);
    check_eq({tag, "_data"},     mem_wdat,  32'h0);
    check_eq({tag, "_bmode"},    mem_bmode, 32'h0);
  endtask

  task automatic reset_now();
    RST = 1'b1;
    q0.delete(); q1.delete();
    req = 2'b00;
    #1;
    check_zero("async_rst");
    @(posedge CLK);
    #2;
    RST = 1'b0;
    model_reset();
  endtask

  initial begin
    RST = 1'b1;
    req = 2'b00; we = 2'b00;
    for (int n = 0; n < 2; n++) begin
      addr[n] = 32'h0; wdata[n] = 32'h0; bmode[n] = 32'h0;
    end
    model_reset();
    @(posedge CLK); #1;
    check_zero("reset_state");
    @(posedge CLK); #2;
    RST = 1'b0;
    model_reset();

    // Port 1 write alone: only port 1 is granted, bmode forwarded
    push(1, 1'b1, 32'h0000_0020, 32'h1234_5678, 32'h0000_000F);
    repeat (4) step();

    // Port 0 write then read-back of the same word
    push(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0003);
    push(0, 1'b0, 32'h0000_0010, 32'h0, 32'h0000_0003);
    repeat (12) step();

    // Both ports hold req for four reads each: tie-breaking order
    for (int i = 0; i < 4; i++) begin
      push(0, 1'b0, 32'(i) << 2, 32'h0, 32'h0000_0001);
      push(1, 1'b0, 32'(i + 4) << 2, 32'h0, 32'h0000_0002);
    end
    repeat (60) step();

    // Reset pulsed mid-WAIT, then a fresh read
    push(0, 1'b0, 32'h0000_0008, 32'h0, 32'h0000_000F);
    for (int k = 0; k < 20; k++) begin
      step();
      if (gnt_cyc > 0 && cyc == gnt_cyc + 2) break;
    end
    #2;
    reset_now();
    repeat (8) step();
    push(0, 1'b0, 32'h0000_0010, 32'h0, 32'h0000_000F);
    repeat (12) step();

    // Randomized traffic from both masters, then drain
    rand_en = 1'b1;
    repeat (600) step();
    rand_en = 1'b0;
    repeat (40) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
